// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: datapath widths, FSM state encodings and
// the slot-select helper used by the line buffer.
package instruction_fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int LINE_W  = 64;
  localparam int SLOTS   = 4;
  localparam int ADDR_W  = 16;
  localparam int TAG_W   = 13;

  // Fetch FSM encodings (FS_HALT is only reachable with ALIGN_CHECK_EN)
  localparam logic [1:0] FS_FILL  = 2'd0;
  localparam logic [1:0] FS_SERVE = 2'd1;
  localparam logic [1:0] FS_HALT  = 2'd2;

  // Pick 16-bit instruction k out of a line; slot 0 sits in bits 15:0
  function automatic logic [INSTR_W-1:0] slot_instr(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        slot);
    logic [INSTR_W-1:0] res;
    case (slot)
      2'd0:    res = line[15:0];
      2'd1:    res = line[31:16];
      2'd2:    res = line[47:32];
      2'd3:    res = line[63:48];
      default: res = line[15:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instruction_fetch_line_buffer.sv
// One-line instruction buffer: holds the last fetched 64-bit line with its
// 13-bit tag, answers hit lookups for redirect targets and muxes out the
// instruction selected by the current PC slot.
module instruction_fetch_line_buffer
  import instruction_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TAG_W-1:0]   load_tag,
  input  logic [LINE_W-1:0]  load_line,
  input  logic [TAG_W-1:0]   lookup_tag,
  input  logic [1:0]         slot,
  output logic               hit,
  output logic [INSTR_W-1:0] instr,
  output logic               line_valid
);

  logic [LINE_W-1:0] line_r;
  logic [TAG_W-1:0]  tag_r;
  logic              valid_r;

  // Capture a returning memory line together with its tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r  <= {LINE_W{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      line_r  <= load_line;
      tag_r   <= load_tag;
      valid_r <= 1'b1;
    end else begin
      line_r  <= line_r;
      tag_r   <= tag_r;
      valid_r <= valid_r;
    end
  end

  assign hit        = valid_r && (lookup_tag == tag_r);
  assign instr      = slot_instr(line_r, slot);
  assign line_valid = valid_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage in front of instruction_memory. Owns the PC, the fill/serve
// FSM and the memory-latency counter; issues one 16-bit instruction per
// valid/ready handshake and services redirects (highest priority).
// Optional feature macro: ALIGN_CHECK_EN (odd redirect target -> sticky
// misalign_err and HALT until reset). Default build ignores redirect_pc[0].
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        misalign_err
);

  localparam int          CNT_W    = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [15:0] PC_RESET = {RESET_PC[15:1], 1'b0};

  logic [15:0]      pc_r, pc_next_s;
  logic [1:0]       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             capture_s;
  logic             hit_s;
  logic             line_valid_s;
  logic             redirect_act_s;
  logic [15:0]      target_pc_s;

`ifdef ALIGN_CHECK_EN
  logic misalign_r, misalign_next_s;
  assign redirect_act_s = redirect && (state_r != FS_HALT);
  assign target_pc_s    = redirect_pc;
`else
  logic unused_bit0_s;
  assign unused_bit0_s  = redirect_pc[0];
  assign redirect_act_s = redirect;
  assign target_pc_s    = {redirect_pc[15:1], 1'b0};
`endif

  instruction_fetch_line_buffer u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (capture_s),
    .load_tag   (pc_r[15:3]),
    .load_line  (mem_data),
    .lookup_tag (redirect_pc[15:3]),
    .slot       (pc_r[2:1]),
    .hit        (hit_s),
    .instr      (instr),
    .line_valid (line_valid_s)
  );

  // Next-state logic: redirect first, then fill counting or slot issue
  always_comb begin
    pc_next_s    = pc_r;
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
`ifdef ALIGN_CHECK_EN
    misalign_next_s = misalign_r;
`endif
    if (redirect_act_s) begin
`ifdef ALIGN_CHECK_EN
      if (target_pc_s[0]) begin
        misalign_next_s = 1'b1;
        state_next_s    = FS_HALT;
        cnt_next_s      = {CNT_W{1'b0}};
      end else begin
        pc_next_s    = target_pc_s;
        state_next_s = (line_valid_s && hit_s) ? FS_SERVE : FS_FILL;
        cnt_next_s   = {CNT_W{1'b0}};
      end
`else
      pc_next_s    = target_pc_s;
      state_next_s = (line_valid_s && hit_s) ? FS_SERVE : FS_FILL;
      cnt_next_s   = {CNT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        FS_FILL: begin
          if (cnt_r == CNT_W'(MEM_LAT)) begin
            capture_s    = 1'b1;
            cnt_next_s   = {CNT_W{1'b0}};
            state_next_s = FS_SERVE;
          end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end
        end
        FS_SERVE: begin
          if (instr_ready) begin
            pc_next_s    = pc_r + 16'd2;
            state_next_s = (pc_r[2:1] == 2'd3) ? FS_FILL : FS_SERVE;
          end else begin
            state_next_s = FS_SERVE;
          end
        end
`ifdef ALIGN_CHECK_EN
        FS_HALT: begin
          state_next_s = FS_HALT;
        end
`endif
        default: begin
          state_next_s = FS_FILL;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // PC, FSM state and latency counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= PC_RESET;
      state_r <= FS_FILL;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      pc_r    <= pc_next_s;
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Sticky odd-target error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else begin
      misalign_r <= misalign_next_s;
    end
  end
  assign misalign_err = misalign_r;
`else
  assign misalign_err = 1'b0;
`endif

  assign mem_addr    = {pc_r[15:3], 3'b000};
  assign instr_pc    = pc_r;
  assign instr_valid = (state_r == FS_SERVE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: 1-cycle synchronous memory
// model, scoreboard of expected (instr, pc) pairs consumed on handshakes,
// plus directed checks of latency, stall, redirect and reset behaviour.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [63:0] mem_data = 64'h0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;
  exp_t sb_q[$];

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_line(input logic [15:0] a);
    case (a[15:3])
      13'd0:   return 64'h4444_3333_2222_1111;
      13'd1:   return 64'h8888_7777_6666_5555;
      13'd2:   return 64'hCCCC_BBBB_AAAA_9999;
      default: return 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
  endfunction

  // Synchronous 1-cycle memory model
  always @(posedge clk) mem_data <= mem_line(mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] i, input logic [15:0] p);
    sb_q.push_back({i, p});
  endtask

  // Score a handshake (if any) then advance one clock; ends on a negedge
  task automatic tick();
    exp_t e;
    if (instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 64'(instr_pc), 64'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_instr", 64'(instr), 64'(e.instr));
        check_eq("sb_pc", 64'(instr_pc), 64'(e.pc));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("sb_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!instr_valid && n < budget) begin
      tick();
      n++;
    end
    if (!instr_valid) check_eq("valid_timeout", 64'(instr_valid), 64'd1);
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    #1;
    check_eq("rst_mem_addr", 64'(mem_addr), 64'h0000);
    check_eq("rst_valid", 64'(instr_valid), 64'd0);
    check_eq("rst_pc", 64'(instr_pc), 64'h0000);
    check_eq("rst_misalign", 64'(misalign_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: stream a full line then cross to the next one
    instr_ready = 1'b1;
    push(16'h1111, 16'h0000); push(16'h2222, 16'h0002);
    push(16'h3333, 16'h0004); push(16'h4444, 16'h0006);
    run_until_empty(20);
    check_eq("t1_bubble", 64'(instr_valid), 64'd0);
    check_eq("t1_mem_addr", 64'(mem_addr), 64'h0008);
    push(16'h5555, 16'h0008);
    run_until_empty(10);

    // 2: miss redirect latency, then stall at pc 0004
    instr_ready = 1'b0;
    do_redirect(16'h0004);
    check_eq("t2_mem_addr", 64'(mem_addr), 64'h0000);
    check_eq("t2_valid_n", 64'(instr_valid), 64'd0);
    wait_valid(10, n);
    check_eq("t2_fill_lat", 64'(n), 64'd2);
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_hold_instr", 64'(instr), 64'h3333);
      check_eq("t2_hold_pc", 64'(instr_pc), 64'h0004);
      check_eq("t2_hold_valid", 64'(instr_valid), 64'd1);
      tick();
    end
    instr_ready = 1'b1;
    push(16'h3333, 16'h0004); push(16'h4444, 16'h0006);
    run_until_empty(10);

    // 3: hit redirect during fill of 0008, then same-line redirect
    instr_ready = 1'b0;
    do_redirect(16'h0002);
    check_eq("t3_hit_valid", 64'(instr_valid), 64'd1);
    check_eq("t3_hit_instr", 64'(instr), 64'h2222);
    check_eq("t3_hit_pc", 64'(instr_pc), 64'h0002);
    do_redirect(16'h0006);
    check_eq("t3_instr", 64'(instr), 64'h4444);
    check_eq("t3_pc", 64'(instr_pc), 64'h0006);
    check_eq("t3_valid", 64'(instr_valid), 64'd1);
    check_eq("t3_mem_addr", 64'(mem_addr), 64'h0000);

    // 4: redirect coincident with handshake, to a missing line
    push(16'h4444, 16'h0006);
    instr_ready = 1'b1;
    do_redirect(16'h0012);
    check_eq("t4_mem_addr", 64'(mem_addr), 64'h0010);
    check_eq("t4_pc", 64'(instr_pc), 64'h0012);
    check_eq("t4_valid", 64'(instr_valid), 64'd0);
    push(16'hAAAA, 16'h0012); push(16'hBBBB, 16'h0014);
    run_until_empty(10);

    // 5: abandon fill of 0010 by redirecting to 0008 mid-fill
    instr_ready = 1'b0;
    do_redirect(16'h0000);
    wait_valid(10, n);
    do_redirect(16'h0010);
    do_redirect(16'h0008);
    check_eq("t5_mem_addr", 64'(mem_addr), 64'h0008);
    wait_valid(10, n);
    instr_ready = 1'b1;
    push(16'h5555, 16'h0008);
    run_until_empty(10);

    // 5b: reset in the middle of a fill
    instr_ready = 1'b0;
    do_redirect(16'h0010);
    tick();
    rst = 1'b1;
    #1;
    check_eq("t5_rst_mem_addr", 64'(mem_addr), 64'h0000);
    check_eq("t5_rst_pc", 64'(instr_pc), 64'h0000);
    check_eq("t5_rst_valid", 64'(instr_valid), 64'd0);
    check_eq("t5_rst_misalign", 64'(misalign_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_valid(10, n);
    check_eq("t5_refill_lat", 64'(n), 64'd2);
    check_eq("t5_refill_instr", 64'(instr), 64'h1111);

    // 6: odd redirect target
    do_redirect(16'h000B);
`ifdef ALIGN_CHECK_EN
    check_eq("t6_misalign", 64'(misalign_err), 64'd1);
    check_eq("t6_valid", 64'(instr_valid), 64'd0);
    do_redirect(16'h0000);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t6_halt_valid", 64'(instr_valid), 64'd0);
    check_eq("t6_halt_misalign", 64'(misalign_err), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("t6_rst_misalign", 64'(misalign_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    wait_valid(10, n);
    check_eq("t6_instr", 64'(instr), 64'h6666);
    check_eq("t6_pc", 64'(instr_pc), 64'h000A);
    check_eq("t6_misalign", 64'(misalign_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
